// File: rtl/inv_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_iter
//
// Iterative AES InvMixColumns engine for the decryption datapath. A 128-bit
// state is accepted on a valid/ready handshake, transformed in place
// COLS_PER_CYCLE columns per clock, then offered on a valid/ready output
// handshake. The per-column GF(2^8) inverse-mix datapath is replicated
// COLS_PER_CYCLE times.
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per BUSY cycle (1, 2 or 4)
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   in_valid_i   : state_i is valid
//   in_ready_o   : block can accept a state (IDLE)
//   state_i      : input state; column c = state_i[127-32c -: 32],
//                  row 0 of each column in bits [31:24]
//   out_valid_o  : state_o holds a finished result (DONE)
//   out_ready_i  : consumer accepts state_o
//   state_o      : transformed state, same byte ordering as state_i
//   busy_o       : high while transforming (BUSY)
// -----------------------------------------------------------------------------
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step and the counter value of the final column group. With
    // four columns per cycle the step is 0 mod 4, so the single group is
    // always both first and last.
    localparam logic [1:0] STEP       = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GROUP = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } fsm_e;

    // -------------------------------------------------------------------------
    // GF(2^8) helpers: multiply by x, and the full inverse column mix built
    // from chained xtime (x2, x4, x8) rather than lookup tables.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a    [4];
        logic [7:0] m9   [4];
        logic [7:0] mb   [4];
        logic [7:0] md   [4];
        logic [7:0] me   [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state wires
    // -------------------------------------------------------------------------
    fsm_e         r_fsm;
    logic [1:0]   r_cnt;
    logic [127:0] r_state;

    fsm_e         w_fsm_next;
    logic [1:0]   w_cnt_next;
    logic [127:0] w_state_next;
    logic         w_load;
    logic         w_step;

    // Column view of the state register and the in-place updated copy.
    logic [31:0]  w_cols      [4];
    logic [31:0]  w_cols_next [4];
    logic [127:0] w_state_step;

    // Per-lane column select and transform.
    logic [1:0]   w_col_idx [COLS_PER_CYCLE];
    logic [31:0]  w_col_in  [COLS_PER_CYCLE];
    logic [31:0]  w_col_out [COLS_PER_CYCLE];

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_cols[c] = r_state[127-32*c -: 32];
        end
    end

    genvar g;
    generate
        for (g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
            // Column indices of a group wrap naturally in the 2-bit counter.
            assign w_col_idx[g] = r_cnt + 2'(g);
            assign w_col_in[g]  = w_cols[w_col_idx[g]];
            assign w_col_out[g] = inv_mix_col(w_col_in[g]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_fsm_next  = r_fsm;
        w_cnt_next  = r_cnt;
        w_load      = 1'b0;
        w_step      = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_load     = 1'b1;
                    w_cnt_next = 2'd0;
                    w_fsm_next = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_o     = 1'b1;
                w_step     = 1'b1;
                w_cnt_next = r_cnt + STEP;
                if (r_cnt == LAST_GROUP) begin
                    w_fsm_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_fsm_next = S_IDLE;
                end
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register datapath: load on accept, in-place column update in BUSY
    // -------------------------------------------------------------------------
    always_comb begin
        w_cols_next = w_cols;
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
            w_cols_next[w_col_idx[l]] = w_col_out[l];
        end
        w_state_step = '0;
        for (int c = 0; c < 4; c++) begin
            w_state_step[127-32*c -: 32] = w_cols_next[c];
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = state_i;
        end else if (w_step) begin
            w_state_next = w_state_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= 2'd0;
            // NOTE: the wide state register is reset on purpose so that an
            // aborted operation never leaves a partial result on state_o.
            r_state <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates
            // from the same pre-edge values.
            r_fsm   <= w_fsm_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    assign state_o = r_state;

endmodule
